// File: rtl/hex_keypad_entry.sv
// 4x4 active-low hex keypad scanner with debounce, live 8-nibble entry word,
// and a debounced ENTER that commits the word over a valid/ready port.
//
// state       | meaning
// ST_SCAN     | rotating the column drive, looking for any low row
// ST_DEBOUNCE | column held, counting consecutive low ticks on the latched row
// ST_RELEASE  | key accepted, waiting for all rows high for DEBOUNCE_TICKS ticks
module hex_keypad_entry #(
    parameter int CLK_DIV        = 32000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    input  logic        enter_n,
    input  logic        clear,
    output logic [31:0] live_data,
    output logic [3:0]  entry_len,
    output logic        key_strobe,
    output logic [3:0]  key_code,
    output logic [31:0] entry_data,
    output logic        entry_valid,
    input  logic        entry_ready
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_TICKS);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_RELEASE  = 2'd2;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    row_meta, row_sync;
    logic          enter_meta, enter_sync;
    logic [1:0]    state, col_idx, row_idx, low_idx;
    logic [CW-1:0] deb_cnt, rel_cnt, enter_cnt;
    logic [CW-1:0] deb_next, rel_next, enter_next;
    logic          enter_armed;
    logic          any_low, accept, commit, do_commit;
    logic [3:0]    key_new, len_base, len_next;
    logic [31:0]   live_base, live_next;

    assign tick       = (div_cnt == DIV_LAST);
    assign col_n      = ~(4'b0001 << col_idx);
    assign any_low    = ~&row_sync;
    assign deb_next   = deb_cnt + CW'(1);
    assign rel_next   = rel_cnt + CW'(1);
    assign enter_next = enter_cnt + CW'(1);
    assign key_new    = {row_idx, col_idx};
    assign accept     = tick && (state == ST_DEBOUNCE) && !row_sync[row_idx] && (deb_next == DEB_MAX);
    assign commit     = tick && enter_armed && !enter_sync && (enter_next == DEB_MAX);
    assign do_commit  = commit && !entry_valid;

    always_comb begin
        low_idx = 2'd3;
        if (!row_sync[0])      low_idx = 2'd0;
        else if (!row_sync[1]) low_idx = 2'd1;
        else if (!row_sync[2]) low_idx = 2'd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            row_meta   <= 4'hF;
            row_sync   <= 4'hF;
            enter_meta <= 1'b1;
            enter_sync <= 1'b1;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + DW'(1);
            row_meta   <= row_n;
            row_sync   <= row_meta;
            enter_meta <= enter_n;
            enter_sync <= enter_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            deb_cnt <= '0;
            rel_cnt <= '0;
        end else if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (any_low) begin
                        row_idx <= low_idx;
                        deb_cnt <= CW'(1);
                        state   <= ST_DEBOUNCE;
                    end else begin
                        col_idx <= col_idx + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_sync[row_idx]) begin
                        if (deb_next == DEB_MAX) begin
                            state   <= ST_RELEASE;
                            rel_cnt <= '0;
                        end else begin
                            deb_cnt <= deb_next;
                        end
                    end else begin
                        state   <= ST_SCAN;
                        col_idx <= col_idx + 2'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!any_low) begin
                        if (rel_next == DEB_MAX) begin
                            state   <= ST_SCAN;
                            rel_cnt <= '0;
                            col_idx <= col_idx + 2'd1;
                        end else begin
                            rel_cnt <= rel_next;
                        end
                    end else begin
                        rel_cnt <= '0;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

    // ENTER: armed means waiting for a press; disarmed means waiting for a clean release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_armed <= 1'b1;
            enter_cnt   <= '0;
        end else if (tick) begin
            if (enter_armed == enter_sync) begin
                enter_cnt <= '0;
            end else if (enter_next == DEB_MAX) begin
                enter_armed <= ~enter_armed;
                enter_cnt   <= '0;
            end else begin
                enter_cnt <= enter_next;
            end
        end
    end

    // A commit empties the live word first, so a same-cycle key lands in a fresh word.
    always_comb begin
        live_base = do_commit ? 32'h0 : live_data;
        len_base  = do_commit ? 4'd0 : entry_len;
        live_next = live_base;
        len_next  = len_base;
        if (accept) begin
            live_next = {live_base[27:0], key_new};
            len_next  = (len_base == 4'd8) ? 4'd8 : len_base + 4'd1;
        end
        if (clear) begin
            live_next = 32'h0;
            len_next  = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_data   <= 32'h0;
            entry_len   <= 4'd0;
            key_strobe  <= 1'b0;
            key_code    <= 4'd0;
            entry_data  <= 32'h0;
            entry_valid <= 1'b0;
        end else begin
            live_data  <= live_next;
            entry_len  <= len_next;
            key_strobe <= accept;
            if (accept) key_code <= key_new;
            if (do_commit) begin
                entry_data  <= live_data;
                entry_valid <= 1'b1;
            end else if (entry_valid && entry_ready) begin
                entry_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a behavioural keypad model
// (CLK_DIV=4, DEBOUNCE_TICKS=3, so one scan tick every 4 clocks).
module tb_hex_keypad_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        enter_n;
    logic        clear;
    logic [31:0] live_data;
    logic [3:0]  entry_len;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [31:0] entry_data;
    logic        entry_valid;
    logic        entry_ready;

    logic        key_down;
    logic [1:0]  key_row, key_col;
    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    int          s0;

    hex_keypad_entry #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n), .enter_n(enter_n),
        .clear(clear), .live_data(live_data), .entry_len(entry_len), .key_strobe(key_strobe),
        .key_code(key_code), .entry_data(entry_data), .entry_valid(entry_valid),
        .entry_ready(entry_ready)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row low only while its column is driven.
    always_comb row_n = (key_down && !col_n[key_col]) ? ~(4'b0001 << key_row) : 4'hF;

    always @(negedge clk) if (key_strobe) strobe_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic type_key(input logic [3:0] code);
        logic found;
        found    = 1'b0;
        key_row  = code[3:2];
        key_col  = code[1:0];
        key_down = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (key_strobe) found = 1'b1;
        end
        check($sformatf("strobe_key_%h", code), 32'(found), 32'd1);
        check($sformatf("code_key_%h", code), 32'(key_code), 32'(code));
        repeat (8) @(negedge clk);
        key_down = 1'b0;
        repeat (32) @(negedge clk);
    endtask

    task automatic press_enter();
        enter_n = 1'b0;
        repeat (20) @(negedge clk);
        enter_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col_n"}, 32'(col_n), 32'hE);
        check({tag, "_live"}, live_data, 32'h0);
        check({tag, "_len"}, 32'(entry_len), 32'h0);
        check({tag, "_strobe"}, 32'(key_strobe), 32'h0);
        check({tag, "_code"}, 32'(key_code), 32'h0);
        check({tag, "_edata"}, entry_data, 32'h0);
        check({tag, "_evalid"}, 32'(entry_valid), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic [3:0] exp_col, c0;

        rst_n = 1'b0; enter_n = 1'b1; clear = 1'b0; entry_ready = 1'b0;
        key_down = 1'b0; key_row = 2'd0; key_col = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // 1: idle scan, 4 clocks per column
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (col_n == 4'b1101) seen = 1'b1;
        end
        check("scan_reach_col1", 32'(seen), 32'd1);
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << ((1 + i / 4) % 4));
            check($sformatf("scan_col_%0d", i), 32'(col_n), 32'(exp_col));
            @(negedge clk);
        end
        check("idle_no_strobe", 32'(strobe_cnt), 32'd0);

        // 2: hold row1/col2 for 10 ticks, one accept
        s0 = strobe_cnt;
        key_row = 2'd1; key_col = 2'd2; key_down = 1'b1;
        repeat (40) @(negedge clk);
        key_down = 1'b0;
        repeat (32) @(negedge clk);
        check("hold_one_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("hold_code", 32'(key_code), 32'h6);
        check("hold_live", live_data, 32'h6);
        check("hold_len", 32'(entry_len), 32'd1);

        // 3: bounce 2 low ticks / 1 high tick never reaches 3 stable ticks
        s0 = strobe_cnt;
        key_row = 2'd2; key_col = 2'd1;
        for (int r = 0; r < 8; r++) begin
            key_down = 1'b1;
            repeat (8) @(negedge clk);
            key_down = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("bounce_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        c0 = col_n;
        repeat (5) @(negedge clk);
        check("bounce_scan_resumes", 32'(col_n != c0), 32'd1);

        // 4: nine keys, oldest nibble shifted out, length saturates
        pulse_clear();
        check("clear_live", live_data, 32'h0);
        for (int k = 1; k <= 9; k++) type_key(4'(k));
        check("nine_live", live_data, 32'h23456789);
        check("nine_len", 32'(entry_len), 32'd8);

        // 5: commit, dropped second commit, handshake
        pulse_clear();
        type_key(4'hA);
        type_key(4'hB);
        check("ab_live", live_data, 32'hAB);
        press_enter();
        check("commit_valid", 32'(entry_valid), 32'd1);
        check("commit_data", entry_data, 32'hAB);
        check("commit_live", live_data, 32'h0);
        check("commit_len", 32'(entry_len), 32'd0);
        type_key(4'hC);
        press_enter();
        check("drop_valid", 32'(entry_valid), 32'd1);
        check("drop_data", entry_data, 32'hAB);
        check("drop_live_kept", live_data, 32'hC);
        entry_ready = 1'b1;
        check("ready_before_edge", 32'(entry_valid), 32'd1);
        @(negedge clk);
        check("ready_clears_valid", 32'(entry_valid), 32'd0);
        entry_ready = 1'b0;

        // 6: clear held across the accept of key 5
        clear = 1'b1;
        type_key(4'h5);
        check("clear_accept_live", live_data, 32'h0);
        check("clear_accept_len", 32'(entry_len), 32'd0);
        clear = 1'b0;

        // 6b: pending entry plus a key in debounce, then async reset
        type_key(4'h7);
        press_enter();
        check("pre_reset_valid", 32'(entry_valid), 32'd1);
        check("pre_reset_data", entry_data, 32'h7);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (col_n == 4'b1110) seen = 1'b1;
        end
        key_row = 2'd0; key_col = 2'd3; key_down = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (col_n == 4'b0111) seen = 1'b1;
        end
        check("reach_col3", 32'(seen), 32'd1);
        repeat (6) @(negedge clk);
        check("debounce_col_held", 32'(col_n), 32'h7);
        s0 = strobe_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (20) @(negedge clk);
        check("reset_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        key_down = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
